// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the byte-addressed data memory.
// Aligned accesses take one native beat; misaligned ones become byte beats that are reassembled little-endian.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsign,
  input  logic [6:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [7:0]  misalign_cnt,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic        dm_half,
  output logic        dm_byte,
  output logic        dm_unsign,
  output logic [6:0]  dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_e;

  state_e      state_q;
  logic        we_q;
  logic        word_q;
  logic        unsign_q;
  logic        mis_q;
  logic [6:0]  addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  beat_q;
  logic [1:0]  last_q;
  logic [31:0] asm_q;
  logic [7:0]  cnt_q;

  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        dm_rd_q, dm_wr_q, dm_half_q, dm_byte_q, dm_unsign_q;
  logic [6:0]  dm_addr_q;
  logic [31:0] dm_wdata_q;

  logic        mis_d;
  logic [1:0]  last_d;
  logic [1:0]  beat_d;
  logic [6:0]  addr_d;
  logic [31:0] wshift_d;
  logic [31:0] asm_d;
  logic [31:0] result_d;

  always_comb begin
    mis_d = 1'b0;
    if (req_size[1])
      mis_d = |req_addr[1:0];
    else if (req_size[0])
      mis_d = req_addr[0];
    last_d = 2'd0;
    if (mis_d)
      last_d = req_size[1] ? 2'd3 : 2'd1;
  end

  always_comb begin
    beat_d   = beat_q + 2'd1;
    addr_d   = addr_q + {5'd0, beat_d};
    wshift_d = wdata_q >> {beat_d, 3'b000};
    asm_d    = asm_q;
    case (beat_q)
      2'd0:    asm_d[7:0]   = dm_rdata[7:0];
      2'd1:    asm_d[15:8]  = dm_rdata[7:0];
      2'd2:    asm_d[23:16] = dm_rdata[7:0];
      default: asm_d[31:24] = dm_rdata[7:0];
    endcase
    // Aligned beats are already extended by the memory; only split accesses need it here.
    if (!mis_q)
      result_d = dm_rdata;
    else if (word_q)
      result_d = asm_d;
    else
      result_d = {(unsign_q ? 16'h0000 : {16{asm_d[15]}}), asm_d[15:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      word_q       <= 1'b0;
      unsign_q     <= 1'b0;
      mis_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      beat_q       <= '0;
      last_q       <= '0;
      asm_q        <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      dm_rd_q      <= 1'b0;
      dm_wr_q      <= 1'b0;
      dm_half_q    <= 1'b0;
      dm_byte_q    <= 1'b0;
      dm_unsign_q  <= 1'b0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          if (req_valid) begin
            state_q     <= BEAT;
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            word_q      <= req_size[1];
            unsign_q    <= req_unsign;
            mis_q       <= mis_d;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            beat_q      <= '0;
            last_q      <= last_d;
            asm_q       <= '0;
            dm_addr_q   <= req_addr;
            dm_rd_q     <= ~req_we;
            dm_wr_q     <= req_we;
            if (mis_d) begin
              dm_byte_q   <= 1'b1;
              dm_half_q   <= 1'b0;
              dm_unsign_q <= 1'b1;
              dm_wdata_q  <= {24'h000000, req_wdata[7:0]};
              if (cnt_q != 8'hFF)
                cnt_q <= cnt_q + 8'd1;
            end else begin
              dm_byte_q   <= (req_size == 2'b00);
              dm_half_q   <= (req_size == 2'b01);
              dm_unsign_q <= req_unsign;
              dm_wdata_q  <= req_wdata;
            end
          end
        end
        BEAT: begin
          asm_q <= asm_d;
          if (beat_q == last_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= we_q ? 32'h0 : result_d;
            dm_rd_q      <= 1'b0;
            dm_wr_q      <= 1'b0;
            dm_half_q    <= 1'b0;
            dm_byte_q    <= 1'b0;
            dm_unsign_q  <= 1'b0;
            dm_addr_q    <= '0;
            dm_wdata_q   <= '0;
          end else begin
            beat_q     <= beat_d;
            dm_addr_q  <= addr_d;
            dm_wdata_q <= {24'h000000, wshift_d[7:0]};
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign misalign_cnt = cnt_q;
  assign dm_rd        = dm_rd_q;
  assign dm_wr        = dm_wr_q;
  assign dm_half      = dm_half_q;
  assign dm_byte      = dm_byte_q;
  assign dm_unsign    = dm_unsign_q;
  assign dm_addr      = dm_addr_q;
  assign dm_wdata     = dm_wdata_q;

endmodule
